// File: rtl/fp_seq_pkg.sv
// Shared types and constants for the fp_alu command sequencer.
// Also holds the fixed-to-float helper used by the converter and the B-operand path.
package fp_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONV,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam int unsigned FRAC_BITS_DEF = 14;

  localparam logic [31:0] FP_POS_SAT = 32'h7FFF_FFFF;
  localparam logic [31:0] FP_NEG_SAT = 32'h8000_0000;

  localparam int unsigned FLAG_OVF = 0;
  localparam int unsigned FLAG_UNF = 1;
  localparam int unsigned FLAG_INV = 2;
  localparam int unsigned FLAG_SAT = 3;
  localparam int unsigned FLAG_TMO = 4;

  // Operation codes, matching the fp_alu opcode set
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;

  // Truncating Qm.frac -> single conversion; 0x80000000 has magnitude 2^31.
  function automatic logic [31:0] fixed_to_float(input logic [31:0] x,
                                                 input int unsigned frac);
    logic [31:0] mag;
    logic [31:0] norm;
    logic [4:0]  p;
    logic [7:0]  e;
    mag = x[31] ? (~x + 32'd1) : x;
    p   = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (mag[i]) p = 5'(i);
    end
    norm = mag << (5'd31 - p);
    e    = 8'(32'd127 + 32'(p) - frac);
    return (x == '0) ? '0 : {x[31], e, norm[30:8]};
  endfunction

endpackage

// File: rtl/fp_op_sequencer_conv.sv
// Combinational fixed<->float converter: fixed_in -> to_float, float_in -> to_fixed/sat.
// Float-to-fixed truncates toward zero and saturates on Inf/NaN or out-of-range exponents.
module fp_fixed_conv
  import fp_seq_pkg::*;
#(
  parameter int unsigned FRAC_BITS = FRAC_BITS_DEF
) (
  input  logic [31:0] fixed_in,
  input  logic [31:0] float_in,
  output logic [31:0] to_float,
  output logic [31:0] to_fixed,
  output logic        sat
);

  logic [31:0] sig;
  logic [31:0] mag;
  int          ex;
  int          sh;
  int unsigned amt;

  always_comb begin
    to_float = fixed_to_float(fixed_in, FRAC_BITS);
    to_fixed = '0;
    sat      = 1'b0;
    mag      = '0;
    amt      = 0;
    sig      = {8'd0, 1'b1, float_in[22:0]};
    ex       = int'(float_in[30:23]) - 127;
    sh       = ex - 23 + int'(FRAC_BITS);
    if (float_in[30:23] != 8'h00) begin
      if (float_in[30:23] == 8'hFF || ex >= 17) begin
        sat      = 1'b1;
        to_fixed = float_in[31] ? FP_NEG_SAT : FP_POS_SAT;
      end else begin
        if (sh >= 0) begin
          amt = unsigned'(sh);
          mag = sig << amt;
        end else if (sh > -32) begin
          amt = unsigned'(-sh);
          mag = sig >> amt;
        end
        to_fixed = float_in[31] ? (~mag + 32'd1) : mag;
      end
    end
  end

endmodule

// File: rtl/fp_op_sequencer.sv
// Command sequencer in front of fp_alu: accepts a request, optionally converts Q17.14
// operands to float, issues a start pulse, waits for done (or times out) and returns a response.
module fp_op_sequencer
  import fp_seq_pkg::*;
#(
  parameter int unsigned FRAC_BITS      = FRAC_BITS_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [3:0]  req_op,
  input  logic        req_fixed,
  output logic [31:0] alu_operand_a,
  output logic [31:0] alu_operand_b,
  output logic [3:0]  alu_operation,
  output logic        alu_start,
  input  logic [31:0] alu_result,
  input  logic        alu_done,
  input  logic        alu_overflow,
  input  logic        alu_underflow,
  input  logic        alu_invalid,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [4:0]  rsp_flags,
  output logic        busy
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  state_t        state;
  logic [31:0]   a_lat;
  logic [31:0]   b_lat;
  logic [3:0]    op_lat;
  logic          fixed_lat;
  logic [CW-1:0] cnt;

  logic [31:0]   a_flt;
  logic [31:0]   res_fix;
  logic          res_sat;
  logic [4:0]    done_flags;

  // One converter: A operand toward the ALU, ALU result back to fixed point
  fp_fixed_conv #(.FRAC_BITS(FRAC_BITS)) u_conv (
    .fixed_in (a_lat),
    .float_in (alu_result),
    .to_float (a_flt),
    .to_fixed (res_fix),
    .sat      (res_sat)
  );

  always_comb begin
    done_flags           = '0;
    done_flags[FLAG_OVF] = alu_overflow;
    done_flags[FLAG_UNF] = alu_underflow;
    done_flags[FLAG_INV] = alu_invalid;
    done_flags[FLAG_SAT] = fixed_lat & res_sat;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      req_ready     <= 1'b1;
      busy          <= 1'b0;
      a_lat         <= '0;
      b_lat         <= '0;
      op_lat        <= '0;
      fixed_lat     <= 1'b0;
      cnt           <= '0;
      alu_operand_a <= '0;
      alu_operand_b <= '0;
      alu_operation <= '0;
      alu_start     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_result    <= '0;
      rsp_flags     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            a_lat     <= req_a;
            b_lat     <= req_b;
            op_lat    <= req_op;
            fixed_lat <= req_fixed;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_CONV;
          end
        end
        ST_CONV: begin
          alu_operand_a <= fixed_lat ? a_flt : a_lat;
          alu_operand_b <= fixed_lat ? fixed_to_float(b_lat, FRAC_BITS) : b_lat;
          alu_operation <= op_lat;
          alu_start     <= 1'b1;
          state         <= ST_ISSUE;
        end
        ST_ISSUE: begin
          alu_start <= 1'b0;
          cnt       <= '0;
          state     <= ST_WAIT;
        end
        ST_WAIT: begin
          cnt <= cnt + 1'b1;
          // done takes priority over a timeout in the same cycle
          if (alu_done) begin
            rsp_result <= fixed_lat ? res_fix : alu_result;
            rsp_flags  <= done_flags;
            rsp_valid  <= 1'b1;
            state      <= ST_RESP;
          end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            rsp_result          <= '0;
            rsp_flags           <= '0;
            rsp_flags[FLAG_TMO] <= 1'b1;
            rsp_valid           <= 1'b1;
            state               <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid     <= 1'b0;
            req_ready     <= 1'b1;
            busy          <= 1'b0;
            alu_operation <= '0;
            state         <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_op_sequencer.sv
// Self-checking bench for fp_op_sequencer: directed table, random ops against a
// numeric reference model, and hand sequences for timeout, backpressure and reset.
module tb_fp_op_sequencer;
  import fp_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_fixed;
  logic [31:0] req_a, req_b;
  logic [3:0]  req_op;
  logic [31:0] alu_operand_a, alu_operand_b, alu_result;
  logic [3:0]  alu_operation;
  logic        alu_start, alu_done, alu_overflow, alu_underflow, alu_invalid;
  logic        rsp_valid, rsp_ready, busy;
  logic [31:0] rsp_result;
  logic [4:0]  rsp_flags;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;

  fp_op_sequencer #(.FRAC_BITS(14), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .req_op(req_op), .req_fixed(req_fixed),
    .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
    .alu_operation(alu_operation), .alu_start(alu_start),
    .alu_result(alu_result), .alu_done(alu_done), .alu_overflow(alu_overflow),
    .alu_underflow(alu_underflow), .alu_invalid(alu_invalid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (alu_start) start_cnt++;

  typedef struct {
    logic [31:0] a, b;
    logic [3:0]  op;
    logic        fixed;
    logic [31:0] res;
    logic [2:0]  fl;      // {invalid, underflow, overflow}
    logic [31:0] e_opa, e_opb, e_res;
    logic [4:0]  e_flags;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: real-valued numbers, exponent found by halving the magnitude
  function automatic logic [31:0] ref_fix2flt(input logic [31:0] x);
    longint m;
    int     p;
    logic [22:0] man;
    if (x == 32'd0) return 32'd0;
    m = x[31] ? (64'sh1_0000_0000 - longint'(x)) : longint'(x);
    p = 0;
    while ((m >> (p + 1)) != 0) p++;
    if (p >= 23) man = 23'((m >> (p - 23)) - (64'sd1 << 23));
    else         man = 23'((m << (23 - p)) - (64'sd1 << 23));
    return {x[31], 8'(127 + p - 14), man};
  endfunction

  function automatic logic [31:0] ref_flt2fix(input logic [31:0] f, output logic sat);
    int  ex;
    real v;
    int  m;
    sat = 1'b0;
    ex  = int'(f[30:23]);
    if (ex == 0) return 32'd0;
    if (ex != 255) begin
      v = (1.0 + real'(f[22:0]) / 8388608.0) * (2.0 ** (ex - 127)) * 16384.0;
      if (v < 2147483648.0) begin
        m = $rtoi(v);
        return f[31] ? 32'(-m) : 32'(m);
      end
    end
    sat = 1'b1;
    return f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
  endfunction

  task automatic send_req(input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] op, input logic fx);
    int n = 0;
    while (!req_ready && n < 100) begin tick(); n++; end
    chk("req_ready_before_req", 32'(req_ready), 32'd1);
    req_a = a; req_b = b; req_op = op; req_fixed = fx; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic await_start();
    int n = 0;
    while (!alu_start && n < 10) begin tick(); n++; end
    chk("alu_start_seen", 32'(alu_start), 32'd1);
  endtask

  // Stub ALU: done presented during WAIT cycle number dly (1-based)
  task automatic give_done(input int dly, input logic [31:0] res, input logic [2:0] fl);
    tick();
    repeat (dly - 1) tick();
    alu_result = res;
    {alu_invalid, alu_underflow, alu_overflow} = fl;
    alu_done = 1'b1;
    tick();
    alu_done = 1'b0;
    alu_result = 32'hDEAD_BEEF;
    {alu_invalid, alu_underflow, alu_overflow} = 3'b000;
  endtask

  task automatic await_rsp();
    int n = 0;
    while (!rsp_valid && n < 100) begin tick(); n++; end
    chk("rsp_valid_seen", 32'(rsp_valid), 32'd1);
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_valid_dropped", 32'(rsp_valid), 32'd0);
    chk("req_ready_after_rsp", 32'(req_ready), 32'd1);
  endtask

  task automatic run_op(input string nm, input vec_t v, input int dly);
    int s0 = start_cnt;
    send_req(v.a, v.b, v.op, v.fixed);
    await_start();
    chk({nm, ".opa"}, alu_operand_a, v.e_opa);
    chk({nm, ".opb"}, alu_operand_b, v.e_opb);
    chk({nm, ".op"}, 32'(alu_operation), 32'(v.op));
    chk({nm, ".busy"}, 32'(busy), 32'd1);
    give_done(dly, v.res, v.fl);
    await_rsp();
    chk({nm, ".result"}, rsp_result, v.e_res);
    chk({nm, ".flags"}, 32'(rsp_flags), 32'(v.e_flags));
    release_rsp();
    chk({nm, ".start_pulses"}, 32'(start_cnt - s0), 32'd1);
  endtask

  function automatic vec_t model_vec(input logic [31:0] a, input logic [31:0] b,
                                     input logic [3:0] op, input logic fx,
                                     input logic [31:0] res, input logic [2:0] fl);
    vec_t v;
    logic s;
    v.a = a; v.b = b; v.op = op; v.fixed = fx; v.res = res; v.fl = fl;
    v.e_opa = fx ? ref_fix2flt(a) : a;
    v.e_opb = fx ? ref_fix2flt(b) : b;
    v.e_res = fx ? ref_flt2fix(res, s) : res;
    v.e_flags = {1'b0, fx & s, fl};
    return v;
  endfunction

  function automatic logic [31:0] rand_fix();
    logic [31:0] x;
    case ($urandom_range(0, 7))
      0: x = 32'd0;
      1: x = 32'h8000_0000;
      default: begin
        x = 32'($urandom) >> $urandom_range(0, 24);
        if ($urandom_range(0, 1) == 1) x = -x;
      end
    endcase
    return x;
  endfunction

  function automatic logic [31:0] rand_flt();
    int unsigned r = $urandom_range(0, 15);
    logic [7:0] e = (r == 0) ? 8'h00 : (r == 1) ? 8'hFF : 8'($urandom_range(100, 150));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  vec_t tbl[9];

  initial begin
    int n, s0;
    logic [31:0] r_hold;
    logic [4:0]  f_hold;
    vec_t v;

    tbl[0] = '{32'h0000_4000, 32'h0000_8000, OP_ADD, 1'b1, 32'h4040_0000, 3'b000,
               32'h3F80_0000, 32'h4000_0000, 32'h0000_C000, 5'b00000};
    tbl[1] = '{32'hFFFF_A000, 32'h0000_4000, OP_SUB, 1'b1, 32'hC020_0000, 3'b000,
               32'hBFC0_0000, 32'h3F80_0000, 32'hFFFF_6000, 5'b00000};
    tbl[2] = '{32'h0000_4000, 32'h0000_4000, OP_MUL, 1'b1, 32'h4B00_0000, 3'b000,
               32'h3F80_0000, 32'h3F80_0000, 32'h7FFF_FFFF, 5'b01000};
    tbl[3] = '{32'h0000_4000, 32'h0000_4000, OP_DIV, 1'b1, 32'hFF80_0000, 3'b001,
               32'h3F80_0000, 32'h3F80_0000, 32'h8000_0000, 5'b01001};
    tbl[4] = '{32'h3F80_0000, 32'hC000_0000, OP_ADD, 1'b0, 32'h7F80_0000, 3'b001,
               32'h3F80_0000, 32'hC000_0000, 32'h7F80_0000, 5'b00001};
    tbl[5] = '{32'h0000_0000, 32'h8000_0000, OP_MUL, 1'b1, 32'h0000_0000, 3'b010,
               32'h0000_0000, 32'hC800_0000, 32'h0000_0000, 5'b00010};
    tbl[6] = '{32'h0000_0001, 32'h7FFF_FFFF, OP_ADD, 1'b1, 32'h4780_0000, 3'b000,
               32'h3880_0000, 32'h47FF_FFFF, 32'h4000_0000, 5'b00000};
    tbl[7] = '{32'h8000_0001, 32'h0000_4000, OP_SUB, 1'b1, 32'h3800_0000, 3'b100,
               32'hC7FF_FFFF, 32'h3F80_0000, 32'h0000_0000, 5'b00100};
    tbl[8] = '{32'h0000_0003, 32'h0000_4000, OP_MUL, 1'b1, 32'h3C00_0000, 3'b000,
               32'h3940_0000, 32'h3F80_0000, 32'h0000_0080, 5'b00000};

    reset_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0;
    req_fixed = 1'b0; rsp_ready = 1'b0; alu_done = 1'b0; alu_result = '0;
    alu_overflow = 1'b0; alu_underflow = 1'b0; alu_invalid = 1'b0;
    #22;
    chk("reset.req_ready", 32'(req_ready), 32'd1);
    chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset.alu_start", 32'(alu_start), 32'd0);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.rsp_result", rsp_result, 32'd0);
    chk("reset.alu_operand_a", alu_operand_a, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) run_op($sformatf("vec%0d", i), tbl[i], (i % 3) + 1);

    for (int i = 0; i < 40; i++) begin
      v = model_vec(rand_fix(), rand_fix(), 4'($urandom_range(0, 3)),
                    ($urandom_range(0, 7) != 0), rand_flt(), 3'($urandom));
      run_op($sformatf("rand%0d", i), v, int'($urandom_range(1, 8)));
    end

    // Done on the last allowed WAIT cycle beats the timeout
    run_op("done_at_limit", tbl[0], 64);

    // Pure timeout: count WAIT cycles until the response appears
    s0 = start_cnt;
    send_req(32'h0000_4000, 32'h0000_4000, OP_ADD, 1'b1);
    await_start();
    n = 0;
    tick();
    while (!rsp_valid && n < 200) begin n++; tick(); end
    chk("timeout.wait_cycles", 32'(n), 32'd64);
    chk("timeout.result", rsp_result, 32'd0);
    chk("timeout.flags", 32'(rsp_flags), 32'b10000);
    chk("timeout.start_pulses", 32'(start_cnt - s0), 32'd1);
    release_rsp();

    // Backpressure with a queued request
    send_req(32'h0000_4000, 32'h0000_8000, OP_ADD, 1'b1);
    await_start();
    give_done(2, 32'hC020_0000, 3'b010);
    await_rsp();
    r_hold = rsp_result;
    f_hold = rsp_flags;
    chk("bp.result", r_hold, 32'hFFFF_6000);
    req_a = 32'h0000_8000; req_b = 32'h0000_4000; req_op = OP_SUB; req_fixed = 1'b1;
    req_valid = 1'b1;
    s0 = start_cnt;
    repeat (10) begin
      tick();
      chk("bp.result_stable", rsp_result, r_hold);
      chk("bp.flags_stable", 32'(rsp_flags), 32'(f_hold));
      chk("bp.req_ready_low", 32'(req_ready), 32'd0);
    end
    chk("bp.no_new_start", 32'(start_cnt - s0), 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp.idle_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    chk("bp.accepted_ready", 32'(req_ready), 32'd0);
    chk("bp.accepted_busy", 32'(busy), 32'd1);
    await_start();
    chk("bp.queued_opa", alu_operand_a, 32'h4000_0000);
    chk("bp.queued_op", 32'(alu_operation), 32'(OP_SUB));
    give_done(1, 32'h4040_0000, 3'b000);
    await_rsp();
    chk("bp.queued_result", rsp_result, 32'h0000_C000);
    release_rsp();

    // Reset in WAIT, then a stray done after release
    s0 = start_cnt;
    send_req(32'h0000_4000, 32'h0000_4000, OP_MUL, 1'b1);
    await_start();
    tick();
    tick();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_wait.req_ready", 32'(req_ready), 32'd1);
    chk("rst_wait.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_wait.alu_start", 32'(alu_start), 32'd0);
    chk("rst_wait.busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    alu_done = 1'b1; alu_result = 32'h4040_0000;
    tick();
    alu_done = 1'b0;
    repeat (3) tick();
    chk("late_done.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("late_done.busy", 32'(busy), 32'd0);
    chk("late_done.req_ready", 32'(req_ready), 32'd1);
    chk("late_done.start_pulses", 32'(start_cnt - s0), 32'd1);

    run_op("after_reset", tbl[1], 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
